// File: rtl/feature_stream_loader.sv
// feature_stream_loader
//
// Accepts a burst request, streams burst_len * N_FEATURE/2 64-bit feature words
// into a downstream feature memory (one write per accepted word, consecutive
// addresses from 0), then fires a one-cycle start pulse to the inference engine
// and waits for its completion pulse before accepting the next request.
//
// Ports
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   cfg_valid/cfg_ready           burst request handshake, cfg_burst_len = inferences
//   in_valid/in_ready             feature word handshake, in_data = two 32-bit features,
//                                 in_last = producer's end-of-burst marker
//   load_features/feature_addr/   registered write port to the feature memory
//   features2
//   burst_len/start/engine_done   downstream engine control
//   busy                          high outside IDLE
//   burst_done                    one-cycle pulse when the engine reports completion
//   err_len                       one-cycle pulse on a rejected burst length
//   err_last                      sticky in_last mismatch, cleared on next accepted request
module feature_stream_loader #(
    parameter int unsigned N_FEATURE = 32,
    parameter int unsigned MAX_BURST = 5000,
    localparam int unsigned LEN_W    = $clog2(MAX_BURST) + 1,
    localparam int unsigned ADDR_W   = $clog2(MAX_BURST * N_FEATURE / 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [LEN_W-1:0]  cfg_burst_len,
    output logic              cfg_ready,
    input  logic              in_valid,
    input  logic [63:0]       in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              load_features,
    output logic [ADDR_W-1:0] feature_addr,
    output logic [63:0]       features2,
    output logic [LEN_W-1:0]  burst_len,
    output logic              start,
    input  logic              engine_done,
    output logic              busy,
    output logic              burst_done,
    output logic              err_len,
    output logic              err_last
);

    localparam int unsigned HALF    = N_FEATURE / 2;
    localparam int unsigned HALF_SH = $clog2(HALF);
    // Wide enough for burst_len * HALF, so the word counter never wraps.
    localparam int unsigned CNT_W   = LEN_W + HALF_SH;

    typedef enum logic [1:0] {StIdle, StLoad, StStart, StRun} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             w_cfg_hs;
    logic             w_in_hs;
    logic             w_len_ok;
    logic [CNT_W-1:0] w_last_idx;
    logic             w_is_last;

    assign cfg_ready = (r_state == StIdle);
    assign in_ready  = (r_state == StLoad);

    assign w_cfg_hs   = cfg_valid && cfg_ready;
    assign w_in_hs    = in_valid && in_ready;
    assign w_len_ok   = (cfg_burst_len != '0) && (32'(cfg_burst_len) <= MAX_BURST);
    // Index of the final word: burst_len * HALF - 1, HALF being a power of two.
    assign w_last_idx = (CNT_W'(burst_len) << HALF_SH) - CNT_W'(1);
    assign w_is_last  = (r_cnt == w_last_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            burst_len     <= '0;
            load_features <= 1'b0;
            feature_addr  <= '0;
            features2     <= '0;
            start         <= 1'b0;
            busy          <= 1'b0;
            burst_done    <= 1'b0;
            err_len       <= 1'b0;
            err_last      <= 1'b0;
        end else begin
            load_features <= 1'b0;
            start         <= 1'b0;
            burst_done    <= 1'b0;
            err_len       <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (w_cfg_hs) begin
                        if (w_len_ok) begin
                            burst_len <= cfg_burst_len;
                            r_cnt     <= '0;
                            err_last  <= 1'b0;
                            busy      <= 1'b1;
                            r_state   <= StLoad;
                        end else begin
                            err_len <= 1'b1;
                        end
                    end
                end

                StLoad: begin
                    if (w_in_hs) begin
                        load_features <= 1'b1;
                        feature_addr  <= r_cnt[ADDR_W-1:0];
                        features2     <= in_data;
                        r_cnt         <= r_cnt + CNT_W'(1);
                        // in_last is only advisory; the word count ends the burst.
                        if (in_last != w_is_last) begin
                            err_last <= 1'b1;
                        end
                        if (w_is_last) begin
                            r_state <= StStart;
                        end
                    end
                end

                // One idle cycle after the last write so start lands strictly after it.
                StStart: begin
                    start   <= 1'b1;
                    r_state <= StRun;
                end

                StRun: begin
                    if (engine_done) begin
                        burst_done <= 1'b1;
                        busy       <= 1'b0;
                        r_state    <= StIdle;
                    end
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_feature_stream_loader.sv
module tb_feature_stream_loader;

    localparam int unsigned N_FEATURE = 32;
    localparam int unsigned MAX_BURST = 5000;
    localparam int unsigned HALF      = N_FEATURE / 2;
    localparam int unsigned LEN_W     = $clog2(MAX_BURST) + 1;
    localparam int unsigned ADDR_W    = $clog2(MAX_BURST * N_FEATURE / 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic [LEN_W-1:0]  cfg_burst_len;
    logic              cfg_ready;
    logic              in_valid;
    logic [63:0]       in_data;
    logic              in_last;
    logic              in_ready;
    logic              load_features;
    logic [ADDR_W-1:0] feature_addr;
    logic [63:0]       features2;
    logic [LEN_W-1:0]  burst_len;
    logic              start;
    logic              engine_done;
    logic              busy;
    logic              burst_done;
    logic              err_len;
    logic              err_last;

    feature_stream_loader #(
        .N_FEATURE(N_FEATURE),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_burst_len(cfg_burst_len),
        .cfg_ready    (cfg_ready),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .load_features(load_features),
        .feature_addr (feature_addr),
        .features2    (features2),
        .burst_len    (burst_len),
        .start        (start),
        .engine_done  (engine_done),
        .busy         (busy),
        .burst_done   (burst_done),
        .err_len      (err_len),
        .err_last     (err_last)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed events, tagged with the cycle they were visible in.
    logic [ADDR_W-1:0] mw_addr[$];
    logic [63:0]       mw_data[$];
    int                mw_cyc[$];
    int                ms_cyc[$];
    int                mb_cyc[$];
    int                me_cyc[$];

    // Reference: every accepted word in order, with the cycle it was accepted in.
    logic [63:0]       exp_data[$];
    int                hs_cyc[$];

    always @(negedge clk) begin
        if (load_features) begin
            mw_addr.push_back(feature_addr);
            mw_data.push_back(features2);
            mw_cyc.push_back(cyc);
        end
        if (start)      ms_cyc.push_back(cyc);
        if (burst_done) mb_cyc.push_back(cyc);
        if (err_len)    me_cyc.push_back(cyc);
    end

    task automatic clear_mon();
        mw_addr.delete(); mw_data.delete(); mw_cyc.delete();
        ms_cyc.delete(); mb_cyc.delete(); me_cyc.delete();
        exp_data.delete(); hs_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_cfg(input int len, output bit acc);
        cfg_valid     = 1'b1;
        cfg_burst_len = LEN_W'(len);
        acc           = cfg_ready;
        @(posedge clk); #1;
        cfg_valid     = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: every other cycle, 2: random.
    task automatic feed(input int base, input int n, input int mode, input int last_idx,
                        input int limit);
        int   sent = 0;
        int   cycles = 0;
        logic v;
        logic rdy;
        logic [63:0] d;
        while (sent < n && cycles < limit) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cycles % 2) == 0)
                                                 : ($urandom_range(0, 3) != 0);
            d = {$urandom, $urandom};
            in_valid = v;
            in_data  = d;
            in_last  = ((base + sent) == last_idx);
            rdy      = in_ready;
            @(posedge clk); #1;
            cycles++;
            if (v && rdy) begin
                exp_data.push_back(d);
                hs_cyc.push_back(cyc - 1);
                sent++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        compared++;
        if (sent != n) begin
            mismatched++;
            $display("FAIL feed_timeout: accepted %0d words, required %0d", sent, n);
        end
    endtask

    task automatic pulse_engine();
        engine_done = 1'b1;
        @(posedge clk); #1;
        engine_done = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        compared++;
        if ({load_features, start, burst_done, err_len, err_last, busy, cfg_ready, in_ready}
            !== 8'b0000_0010) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b required 00000010",
                     {load_features, start, burst_done, err_len, err_last, busy, cfg_ready,
                      in_ready});
        end
        compared++;
        if (burst_len !== '0 || feature_addr !== '0) begin
            mismatched++;
            $display("FAIL reset_regs: burst_len %0d addr %0d required 0 0", burst_len,
                     feature_addr);
        end
        rst = 1'b0;
        idle(1);
        compared++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: cfg_ready %b busy %b required 1 0", cfg_ready, busy);
        end
    endtask

    task automatic test_back_to_back(input int mode);
        bit acc;
        int w = 3 * HALF;
        clear_mon();
        do_cfg(3, acc);
        compared++;
        if (!acc || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_accept: acc %0d busy %b required 1 1", acc, busy);
        end
        feed(0, w, mode, w - 1, 400);
        idle(3);
        compared++;
        if (mw_addr.size() != w) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d writes required %0d", mw_addr.size(), w);
        end
        for (int i = 0; i < w && i < mw_addr.size(); i++) begin
            compared++;
            if (mw_addr[i] !== ADDR_W'(i) || mw_data[i] !== exp_data[i]
                || mw_cyc[i] != hs_cyc[i] + 1) begin
                mismatched++;
                $display("FAIL b2b_write%0d: addr %0d data %h cyc %0d required %0d %h %0d", i,
                         mw_addr[i], mw_data[i], mw_cyc[i], i, exp_data[i], hs_cyc[i] + 1);
            end
        end
        compared++;
        if (ms_cyc.size() != 1 || ms_cyc[0] != hs_cyc[w-1] + 2) begin
            mismatched++;
            $display("FAIL b2b_start: %0d pulses first at %0d required 1 at %0d",
                     ms_cyc.size(), (ms_cyc.size() > 0) ? ms_cyc[0] : -1, hs_cyc[w-1] + 2);
        end
        compared++;
        if (err_last !== 1'b0 || burst_len !== LEN_W'(3) || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_status: err_last %b burst_len %0d busy %b required 0 3 1",
                     err_last, burst_len, busy);
        end
        pulse_engine();
        compared++;
        if (cfg_ready !== 1'b1 || mb_cyc.size() != 1) begin
            mismatched++;
            $display("FAIL b2b_done: cfg_ready %b burst_done pulses %0d required 1 1",
                     cfg_ready, mb_cyc.size());
        end
    endtask

    task automatic test_len_err();
        bit acc;
        logic [LEN_W-1:0] bl_before = burst_len;
        clear_mon();
        do_cfg(0, acc);
        compared++;
        if (err_len !== 1'b1 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL len_zero: err_len %b busy %b cfg_ready %b required 1 0 1", err_len,
                     busy, cfg_ready);
        end
        do_cfg(MAX_BURST + 1, acc);
        compared++;
        if (err_len !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL len_over: err_len %b busy %b required 1 0", err_len, busy);
        end
        idle(2);
        compared++;
        if (me_cyc.size() != 2 || mw_addr.size() != 0 || burst_len !== bl_before
            || err_len !== 1'b0) begin
            mismatched++;
            $display("FAIL len_after: err pulses %0d writes %0d burst_len %0d err_len %b required 2 0 %0d 0",
                     me_cyc.size(), mw_addr.size(), burst_len, err_len, bl_before);
        end
    endtask

    task automatic test_err_last();
        bit acc;
        int w = HALF;
        clear_mon();
        do_cfg(1, acc);
        feed(0, w, 2, 7, 200);
        idle(3);
        compared++;
        if (mw_addr.size() != w) begin
            mismatched++;
            $display("FAIL errlast_count: got %0d writes required %0d", mw_addr.size(), w);
        end
        for (int i = 0; i < w && i < mw_addr.size(); i++) begin
            compared++;
            if (mw_addr[i] !== ADDR_W'(i) || mw_data[i] !== exp_data[i]) begin
                mismatched++;
                $display("FAIL errlast_write%0d: addr %0d data %h required %0d %h", i,
                         mw_addr[i], mw_data[i], i, exp_data[i]);
            end
        end
        compared++;
        if (ms_cyc.size() != 1 || err_last !== 1'b1) begin
            mismatched++;
            $display("FAIL errlast_flag: start pulses %0d err_last %b required 1 1",
                     ms_cyc.size(), err_last);
        end
        pulse_engine();
        compared++;
        if (err_last !== 1'b1) begin
            mismatched++;
            $display("FAIL errlast_sticky: got %b required 1", err_last);
        end
        do_cfg(1, acc);
        compared++;
        if (err_last !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL errlast_clear: err_last %b busy %b required 0 1", err_last, busy);
        end
        clear_mon();
        feed(0, w, 0, w - 1, 100);
        idle(3);
        pulse_engine();
    endtask

    task automatic test_engine_done();
        bit acc;
        int w = 2 * HALF;
        clear_mon();
        do_cfg(2, acc);
        feed(0, 8, 0, w - 1, 100);
        engine_done = 1'b1;
        @(posedge clk); #1;
        engine_done = 1'b0;
        compared++;
        if (burst_done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL eng_in_load: burst_done %b busy %b in_ready %b required 0 1 1",
                     burst_done, busy, in_ready);
        end
        feed(8, w - 8, 0, w - 1, 100);
        idle(3);
        compared++;
        if (mw_addr.size() != w || ms_cyc.size() != 1 || mb_cyc.size() != 0) begin
            mismatched++;
            $display("FAIL eng_load: writes %0d starts %0d dones %0d required %0d 1 0",
                     mw_addr.size(), ms_cyc.size(), mb_cyc.size(), w);
        end
        engine_done = 1'b1;
        @(posedge clk); #1;
        engine_done = 1'b0;
        compared++;
        if (burst_done !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL eng_in_run: burst_done %b cfg_ready %b busy %b required 1 1 0",
                     burst_done, cfg_ready, busy);
        end
        idle(1);
        compared++;
        if (burst_done !== 1'b0 || mb_cyc.size() != 1) begin
            mismatched++;
            $display("FAIL eng_pulse: burst_done %b pulses %0d required 0 1", burst_done,
                     mb_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        int w = 2 * HALF;
        clear_mon();
        do_cfg(3, acc);
        feed(0, 21, 0, 3 * HALF - 1, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        compared++;
        if ({load_features, start, burst_done, err_len, err_last, busy, cfg_ready, in_ready}
            !== 8'b0000_0010 || burst_len !== '0 || feature_addr !== '0) begin
            mismatched++;
            $display("FAIL midrst_state: ctrl %b burst_len %0d addr %0d required 00000010 0 0",
                     {load_features, start, burst_done, err_len, err_last, busy, cfg_ready,
                      in_ready}, burst_len, feature_addr);
        end
        idle(3);
        compared++;
        if (ms_cyc.size() != 0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_resume: starts %0d busy %b required 0 0", ms_cyc.size(), busy);
        end
        clear_mon();
        do_cfg(2, acc);
        feed(0, w, 2, w - 1, 300);
        idle(3);
        compared++;
        if (mw_addr.size() != w) begin
            mismatched++;
            $display("FAIL midrst_count: got %0d writes required %0d", mw_addr.size(), w);
        end
        for (int i = 0; i < w && i < mw_addr.size(); i++) begin
            compared++;
            if (mw_addr[i] !== ADDR_W'(i) || mw_data[i] !== exp_data[i]) begin
                mismatched++;
                $display("FAIL midrst_write%0d: addr %0d data %h required %0d %h", i,
                         mw_addr[i], mw_data[i], i, exp_data[i]);
            end
        end
        compared++;
        if (ms_cyc.size() != 1 || burst_len !== LEN_W'(2)) begin
            mismatched++;
            $display("FAIL midrst_start: starts %0d burst_len %0d required 1 2", ms_cyc.size(),
                     burst_len);
        end
        pulse_engine();
    endtask

    task automatic test_random();
        bit acc;
        for (int k = 0; k < 4; k++) begin
            int len = $urandom_range(1, 4);
            int w = len * HALF;
            int last_idx = ($urandom_range(0, 1) != 0) ? w - 1 : $urandom_range(0, w);
            logic exp_err = (last_idx != w - 1);
            clear_mon();
            do_cfg(len, acc);
            feed(0, w, 2, last_idx, 20 * w);
            idle(3);
            compared++;
            if (mw_addr.size() != w) begin
                mismatched++;
                $display("FAIL rnd%0d_count: got %0d writes required %0d", k, mw_addr.size(), w);
            end
            for (int i = 0; i < w && i < mw_addr.size(); i++) begin
                compared++;
                if (mw_addr[i] !== ADDR_W'(i) || mw_data[i] !== exp_data[i]
                    || mw_cyc[i] != hs_cyc[i] + 1) begin
                    mismatched++;
                    $display("FAIL rnd%0d_write%0d: addr %0d data %h cyc %0d required %0d %h %0d",
                             k, i, mw_addr[i], mw_data[i], mw_cyc[i], i, exp_data[i],
                             hs_cyc[i] + 1);
                end
            end
            compared++;
            if (ms_cyc.size() != 1 || ms_cyc[0] != hs_cyc[w-1] + 2 || err_last !== exp_err
                || burst_len !== LEN_W'(len)) begin
                mismatched++;
                $display("FAIL rnd%0d_end: starts %0d err_last %b burst_len %0d required 1 %b %0d",
                         k, ms_cyc.size(), err_last, burst_len, exp_err, len);
            end
            pulse_engine();
        end
    endtask

    initial begin
        rst           = 1'b1;
        cfg_valid     = 1'b0;
        cfg_burst_len = '0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        engine_done   = 1'b0;
        test_reset();
        test_back_to_back(0);
        test_back_to_back(1);
        test_len_err();
        test_err_last();
        test_engine_done();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/feature_stream_loader.md
FEATURE_STREAM_LOADER -- requirements
Module: feature_stream_loader

Interface
REQ-001 SHALL have parameter N_FEATURE, default 32, meaning 32-bit features per inference (even, power of two); HALF = N_FEATURE/2 64-bit words per inference.
REQ-002 SHALL have parameter MAX_BURST, default 5000, meaning maximum inferences per burst.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 cfg_valid  in  1  burst request.
REQ-007 cfg_burst_len  in  $clog2(MAX_BURST)+1  requested inferences.
REQ-008 cfg_ready  out  1  request accepted when cfg_valid && cfg_ready.
REQ-009 in_valid  in  1  feature word valid.
REQ-010 in_data  in  64  two packed 32-bit features, low feature in [31:0].
REQ-011 in_last  in  1  marks final word of burst.
REQ-012 in_ready  out  1  word accepted when in_valid && in_ready.
REQ-013 load_features  out  1  write strobe to downstream feature memory.
REQ-014 feature_addr  out  $clog2(MAX_BURST*N_FEATURE/2)  word address.
REQ-015 features2  out  64  word written.
REQ-016 burst_len  out  $clog2(MAX_BURST)+1  burst length to downstream engine.
REQ-017 start  out  1  one-cycle start pulse to downstream engine.
REQ-018 engine_done  in  1  one-cycle completion pulse from downstream engine.
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 burst_done  out  1  one-cycle pulse when burst completes.
REQ-021 err_len  out  1  one-cycle pulse on rejected request.
REQ-022 err_last  out  1  sticky in_last mismatch flag, cleared on next accepted request.

Function
REQ-023 FSM states IDLE, LOAD, START, RUN; all outputs registered except cfg_ready/in_ready (decoded from state).
REQ-024 IDLE: cfg_ready=1; on handshake with 1 <= cfg_burst_len <= MAX_BURST: latch burst_len, clear word counter and err_last, go LOAD.
REQ-025 IDLE: on handshake with cfg_burst_len 0 or > MAX_BURST: err_len pulse next cycle, stay IDLE, burst_len unchanged.
REQ-026 LOAD: in_ready=1, cfg_ready=0; expected words W = burst_len*HALF.
REQ-027 Word accepted in cycle t SHALL produce load_features=1, feature_addr=counter, features2=in_data in cycle t+1; counter increments by 1 per accepted word, no gaps.
REQ-028 load_features SHALL be 0 in any cycle with no handshake in the prior cycle; in_valid low inserts bubbles without state change.
REQ-029 Word W-1 accepted at t: go START at t+1; start=1 at t+2 exactly one cycle, strictly after last write; then RUN.
REQ-030 in_last high on a word other than W-1, or low on word W-1, SHALL set err_last; count-based termination governs regardless of in_last.
REQ-031 START/RUN: in_ready=0, cfg_ready=0; RUN waits for engine_done, then burst_done pulse next cycle and return to IDLE.
REQ-032 engine_done outside RUN SHALL be ignored.
REQ-033 burst_len SHALL hold its value from acceptance until the next accepted request.
REQ-034 Counter arithmetic SHALL be wide enough for MAX_BURST*HALF-1 without wrap; W computed by shift (HALF power of two).

Reset
REQ-035 rst high at any clock edge, including mid-LOAD or RUN: state IDLE, counter 0, burst_len 0, load_features/start/burst_done/err_len 0, err_last 0, busy 0; no partial burst resumes.

Verification
REQ-036 N_FEATURE=32, cfg_burst_len=3, 48 words back-to-back with in_last on word 47 -> addresses 0..47 in order, start single pulse 2 cycles after word-47 handshake, err_last=0.
REQ-037 Same burst with in_valid toggled every other cycle -> identical address/data sequence, 48 load_features pulses total, one start.
REQ-038 cfg_burst_len=0, then MAX_BURST+1 -> err_len pulse each, busy stays 0, no writes.
REQ-039 burst_len=1, in_last on word 7 -> err_last=1, loading continues to word 15, start pulses; next accepted request clears err_last.
REQ-040 engine_done pulsed in LOAD then in RUN -> first ignored; second gives burst_done next cycle, cfg_ready=1 after.
REQ-041 rst asserted after word 20 of 48 -> all outputs at reset values next cycle; new burst_len=2 loads addresses from 0.
